// File: rtl/led_alarm_pkg.sv
// led_alarm_pkg: shared types and constants for the alarm LED sequencer.
//   alarm_state_t : sequencer state encoding
//   MODE_*        : display mode encoding on the mode input
// Optional feature macro: LED_ALARM_SNOOZE_EN (adds the ST_SNOOZE state).
package led_alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLINK = 2'd1,
    ST_CHASE = 2'd2
`ifdef LED_ALARM_SNOOZE_EN
    ,
    ST_SNOOZE = 2'd3
`endif
  } alarm_state_t;

  localparam logic [1:0] MODE_BLINK = 2'd0;
  localparam logic [1:0] MODE_CHASE = 2'd1;
  localparam logic [1:0] MODE_ALT   = 2'd2;

endpackage

// File: rtl/led_alarm_seq_timer.sv
// led_tick_timer: free-running tick counter with terminal hit.
//   clk, rst : clock, synchronous active-high reset
//   clr      : force count to 0 (wins over en)
//   en       : advance count; wraps to 0 after reaching MAX-1
//   count    : current count, W bits
//   hit      : count == MAX-1
module led_tick_timer #(
  parameter int unsigned MAX = 2,
  parameter int unsigned W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         hit
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign hit   = (count_q == W'(MAX - 1));
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = hit ? '0 : count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/led_alarm_seq.sv
// led_alarm_seq: alarm LED bar sequencer (blink / chase / alternate).
//   clk, rst : clock, synchronous active-high reset
//   start    : alarm request; rising edge starts or retriggers
//   stop     : rising edge silences the alarm (no done pulse)
//   mode     : 0 blink, 1 chase, 2 alternate, 3 as blink; sampled on start edge
//   snooze   : rising edge pauses the display (only with LED_ALARM_SNOOZE_EN)
//   led      : LED bar drive
//   active   : high in any non-idle state
//   done     : one-cycle pulse when the alarm duration expires
// Optional feature macro: LED_ALARM_SNOOZE_EN.
//
// state     | meaning
// ----------+--------------------------------------------------
// ST_IDLE   | alarm off, led dark, all timers held at 0
// ST_BLINK  | whole bar toggles every BLINK_TICKS clocks
// ST_CHASE  | single lit LED rotates left every STEP_TICKS clocks
// ST_SNOOZE | led dark for SNOOZE_TICKS, alarm timer keeps running
module led_alarm_seq
  import led_alarm_pkg::*;
#(
  parameter int unsigned N_LEDS       = 14,
  parameter int unsigned BLINK_TICKS  = 12_000_000,
  parameter int unsigned STEP_TICKS   = 6_000_000,
  parameter int unsigned PHASE_TICKS  = 48_000_000,
  parameter int unsigned ALARM_TICKS  = 500_000_000,
  parameter int unsigned SNOOZE_TICKS = 300_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        mode,
`ifdef LED_ALARM_SNOOZE_EN
  input  logic              snooze,
`endif
  output logic [N_LEDS-1:0] led,
  output logic              active,
  output logic              done
);

  localparam int unsigned BLINK_W = $clog2(BLINK_TICKS + 1);
  localparam int unsigned STEP_W  = $clog2(STEP_TICKS + 1);
  localparam int unsigned PHASE_W = $clog2(PHASE_TICKS + 1);
  localparam int unsigned ALARM_W = $clog2(ALARM_TICKS + 1);

  alarm_state_t      state_q, state_d;
  logic [N_LEDS-1:0] led_q, led_d;
  logic [1:0]        mode_q, mode_d;
  logic              done_q, done_d;
  logic              start_q, stop_q;

  logic start_edge, stop_edge;
  logic [1:0] mode_norm;

  logic clr_all, clr_disp;
  logic blink_en, step_en, phase_en, alarm_en;
  logic blink_hit, step_hit, phase_hit, alarm_hit;

  logic [BLINK_W-1:0] blink_cnt_unused;
  logic [STEP_W-1:0]  step_cnt_unused;
  logic [PHASE_W-1:0] phase_cnt_unused;
  logic [ALARM_W-1:0] alarm_cnt_unused;

  function automatic alarm_state_t init_state(input logic [1:0] m);
    return (m == MODE_CHASE) ? ST_CHASE : ST_BLINK;
  endfunction

  function automatic logic [N_LEDS-1:0] init_led(input logic [1:0] m);
    return (m == MODE_CHASE) ? N_LEDS'(1) : {N_LEDS{1'b1}};
  endfunction

  assign start_edge = start & ~start_q;
  assign stop_edge  = stop & ~stop_q;
  // Mode 3 is folded onto blink at latch time so later decode never sees it.
  assign mode_norm  = ((mode == MODE_CHASE) || (mode == MODE_ALT)) ? mode : MODE_BLINK;

  assign blink_en = (state_q == ST_BLINK);
  assign step_en  = (state_q == ST_CHASE);
  assign phase_en = ((state_q == ST_BLINK) || (state_q == ST_CHASE)) && (mode_q == MODE_ALT);
  assign alarm_en = (state_q != ST_IDLE);

  led_tick_timer #(.MAX(BLINK_TICKS)) u_blink_tmr (
    .clk(clk), .rst(rst), .clr(clr_all | clr_disp), .en(blink_en),
    .count(blink_cnt_unused), .hit(blink_hit)
  );

  led_tick_timer #(.MAX(STEP_TICKS)) u_step_tmr (
    .clk(clk), .rst(rst), .clr(clr_all | clr_disp), .en(step_en),
    .count(step_cnt_unused), .hit(step_hit)
  );

  led_tick_timer #(.MAX(PHASE_TICKS)) u_phase_tmr (
    .clk(clk), .rst(rst), .clr(clr_all | clr_disp), .en(phase_en),
    .count(phase_cnt_unused), .hit(phase_hit)
  );

  led_tick_timer #(.MAX(ALARM_TICKS)) u_alarm_tmr (
    .clk(clk), .rst(rst), .clr(clr_all), .en(alarm_en),
    .count(alarm_cnt_unused), .hit(alarm_hit)
  );

`ifdef LED_ALARM_SNOOZE_EN
  localparam int unsigned SNOOZE_W = $clog2(SNOOZE_TICKS + 1);

  logic                snooze_q;
  logic                snooze_edge;
  logic                snooze_hit;
  logic [SNOOZE_W-1:0] snooze_cnt_unused;

  assign snooze_edge = snooze & ~snooze_q;

  // Wraps to 0 on its own hit, so it is already cleared when SNOOZE is next entered.
  led_tick_timer #(.MAX(SNOOZE_TICKS)) u_snooze_tmr (
    .clk(clk), .rst(rst), .clr(clr_all), .en(state_q == ST_SNOOZE),
    .count(snooze_cnt_unused), .hit(snooze_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      snooze_q <= 1'b0;
    end else begin
      snooze_q <= snooze;
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    led_d    = led_q;
    mode_d   = mode_q;
    done_d   = 1'b0;
    clr_all  = 1'b0;
    clr_disp = 1'b0;

    if (state_q == ST_IDLE) begin
      clr_all = 1'b1;
      if (start_edge) begin
        mode_d  = mode_norm;
        state_d = init_state(mode_norm);
        led_d   = init_led(mode_norm);
      end
    end else if (stop_edge) begin
      state_d = ST_IDLE;
      led_d   = '0;
      clr_all = 1'b1;
    end else if (start_edge) begin
      mode_d  = mode_norm;
      state_d = init_state(mode_norm);
      led_d   = init_led(mode_norm);
      clr_all = 1'b1;
    end else if (alarm_hit) begin
      state_d = ST_IDLE;
      led_d   = '0;
      done_d  = 1'b1;
      clr_all = 1'b1;
`ifdef LED_ALARM_SNOOZE_EN
    end else if (state_q == ST_SNOOZE) begin
      if (snooze_hit) begin
        state_d  = init_state(mode_q);
        led_d    = init_led(mode_q);
        clr_disp = 1'b1;
      end
    end else if (snooze_edge) begin
      state_d  = ST_SNOOZE;
      led_d    = '0;
      clr_disp = 1'b1;
`endif
    end else if (phase_en && phase_hit) begin
      state_d  = (state_q == ST_BLINK) ? ST_CHASE : ST_BLINK;
      led_d    = (state_q == ST_BLINK) ? N_LEDS'(1) : {N_LEDS{1'b1}};
      clr_disp = 1'b1;
    end else if (blink_en && blink_hit) begin
      led_d = ~led_q;
    end else if (step_en && step_hit) begin
      led_d = {led_q[N_LEDS-2:0], led_q[N_LEDS-1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      led_q   <= '0;
      mode_q  <= MODE_BLINK;
      done_q  <= 1'b0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      led_q   <= led_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
      start_q <= start;
      stop_q  <= stop;
    end
  end

  assign led    = led_q;
  assign active = (state_q != ST_IDLE);
  assign done   = done_q;

endmodule

// File: tb/tb_led_alarm_seq.sv
// tb_led_alarm_seq: directed scenarios plus random stimulus for led_alarm_seq,
// checked every cycle against a time-based model of the display.
module tb_led_alarm_seq;

  localparam int N  = 4;
  localparam int BT = 3;
  localparam int ST = 2;
  localparam int PT = 12;
  localparam int AT = 40;
  localparam int SZ = 5;
`ifdef LED_ALARM_SNOOZE_EN
  localparam bit SNZ_EN = 1'b1;
`else
  localparam bit SNZ_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, start, stop;
  logic [1:0]   mode;
  logic         snooze;
  logic [N-1:0] led;
  logic         active, done;

  int n_vec = 0;
  int n_err = 0;

  // model: alarm time since entry, display time since segment start, snooze time
  bit m_act, m_snz, m_done;
  int m_mode, m_ta, m_ts, m_tz;
  bit p_start, p_stop, p_snooze;

  always #5 clk = ~clk;

  led_alarm_seq #(
    .N_LEDS(N), .BLINK_TICKS(BT), .STEP_TICKS(ST), .PHASE_TICKS(PT),
    .ALARM_TICKS(AT), .SNOOZE_TICKS(SZ)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
`ifdef LED_ALARM_SNOOZE_EN
    .snooze(snooze),
`endif
    .led(led), .active(active), .done(done)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] exp_led();
    int  o;
    bit  chase;
    if (!m_act || m_snz) return '0;
    o     = m_ts;
    chase = (m_mode == 1);
    if (m_mode == 2) begin
      chase = ((m_ts / PT) % 2) == 1;
      o     = m_ts % PT;
    end
    if (chase) return N'(1) << ((o / ST) % N);
    return (((o / BT) % 2) == 0) ? {N{1'b1}} : '0;
  endfunction

  task automatic restart(input logic [1:0] md);
    m_act  = 1;
    m_snz  = 0;
    m_mode = (md == 2'd3) ? 0 : int'(md);
    m_ta   = 0;
    m_ts   = 0;
    m_tz   = 0;
  endtask

  task automatic model_step(input bit r, input bit st, input bit sp, input bit sn,
                            input logic [1:0] md);
    bit se, pe, ne;
    se = st && !p_start;
    pe = sp && !p_stop;
    ne = SNZ_EN && sn && !p_snooze;
    m_done = 0;
    if (r) begin
      m_act = 0; m_snz = 0; m_ta = 0; m_ts = 0; m_tz = 0;
      p_start = 0; p_stop = 0; p_snooze = 0;
    end else begin
      if (!m_act) begin
        if (se) restart(md);
      end else if (pe) begin
        m_act = 0; m_snz = 0;
      end else if (se) begin
        restart(md);
      end else if (m_ta + 1 == AT) begin
        m_act = 0; m_snz = 0; m_done = 1;
      end else begin
        m_ta++;
        if (ne && !m_snz) begin
          m_snz = 1; m_tz = 0;
        end else if (m_snz) begin
          m_tz++;
          if (m_tz == SZ) begin
            m_snz = 0; m_ts = 0;
          end
        end else begin
          m_ts++;
        end
      end
      p_start = st; p_stop = sp; p_snooze = sn;
    end
  endtask

  // check the state settled by the previous edge, then apply the next inputs
  task automatic cyc(input bit r, input bit st, input bit sp, input bit sn,
                     input logic [1:0] md);
    @(negedge clk);
    check_eq("led", 32'(led), 32'(exp_led()));
    check_eq("active", 32'(active), 32'(m_act));
    check_eq("done", 32'(done), 32'(m_done));
    rst = r; start = st; stop = sp; snooze = sn; mode = md;
    model_step(r, st, sp, sn, md);
  endtask

  task automatic hold(input int n, input bit st, input logic [1:0] md);
    for (int i = 0; i < n; i++) cyc(1'b0, st, 1'b0, 1'b0, md);
  endtask

  initial begin
    bit r, st, sp, sn;
    logic [1:0] md;

    rst = 1'b1; start = 1'b0; stop = 1'b0; snooze = 1'b0; mode = 2'd0;
    model_step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    repeat (2) @(posedge clk);

    hold(3, 1'b0, 2'd0);

    // mode 0 through to timeout
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    hold(45, 1'b0, 2'd1);
    // mode 1 chase, then stop
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'd1);
    hold(12, 1'b0, 2'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    hold(3, 1'b0, 2'd0);
    // alternate through to timeout
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'd2);
    hold(45, 1'b0, 2'd0);
    // stop at 10, retrigger from idle at 20 in chase, then retrigger mid-alarm
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'd3);
    hold(9, 1'b0, 2'd3);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 2'd3);
    hold(9, 1'b0, 2'd3);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'd1);
    hold(15, 1'b0, 2'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'd2);
    hold(45, 1'b0, 2'd0);
    // start held high: a single alarm
    hold(100, 1'b1, 2'd0);
    hold(2, 1'b0, 2'd0);
    // reset mid-alarm
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'd1);
    hold(7, 1'b0, 2'd1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
    hold(3, 1'b0, 2'd1);
    // snooze at 8, resume, snooze again and stop inside it
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    hold(7, 1'b0, 2'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
    hold(10, 1'b0, 2'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
    hold(2, 1'b0, 2'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    hold(3, 1'b0, 2'd0);

    // random traffic on all inputs
    st = 0; sp = 0; sn = 0;
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 399) == 0);
      st = st ^ ($urandom_range(0, 29) == 0);
      sp = sp ^ ($urandom_range(0, 49) == 0);
      sn = sn ^ ($urandom_range(0, 19) == 0);
      md = 2'($urandom_range(0, 3));
      cyc(r, st, sp, sn, md);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
